// File: rtl/pic_pkg.sv
// Shared constants and types for the 8259-style control logic.
package pic_pkg;

    localparam int unsigned IRQ_W = 8;
    localparam int unsigned LVL_W = 3;

    // Strobe bit positions inside icw_wr[4:1] / ocw_wr[3:1]
    localparam int unsigned ICW1 = 1;
    localparam int unsigned ICW2 = 2;
    localparam int unsigned ICW3 = 3;
    localparam int unsigned ICW4 = 4;
    localparam int unsigned OCW1 = 1;
    localparam int unsigned OCW2 = 2;
    localparam int unsigned OCW3 = 3;

    // OCW2 command field din[7:5]
    localparam logic [2:0] EOI_NS = 3'b001;
    localparam logic [2:0] EOI_SP = 3'b011;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_INTA1 = 2'd1,
        WAIT_INTA2 = 2'd2
    } pic_state_t;

    // One-hot mask for an interrupt level
    function automatic logic [IRQ_W-1:0] lvl_mask(input logic [LVL_W-1:0] lvl);
        return IRQ_W'(1) << lvl;
    endfunction

endpackage

// File: rtl/pic_control_logic_if.sv
// Bundle between the read/write block / CPU side (master) and the control logic (slave).
interface pic_control_logic_if;
    import pic_pkg::*;

    logic [IRQ_W-1:0] din;
    logic [4:1]       icw_wr;
    logic [3:1]       ocw_wr;
    logic             end_of_init;
    logic [IRQ_W-1:0] ir;
    logic             inta_n;
    logic             int_out;
    logic [IRQ_W-1:0] vector_out;
    logic             vector_en;
    logic [IRQ_W-1:0] irr;
    logic [IRQ_W-1:0] isr;
    logic [IRQ_W-1:0] imr;
    logic             read_isr;

    modport master (
        output din, icw_wr, ocw_wr, end_of_init, ir, inta_n,
        input  int_out, vector_out, vector_en, irr, isr, imr, read_isr
    );

    modport slave (
        input  din, icw_wr, ocw_wr, end_of_init, ir, inta_n,
        output int_out, vector_out, vector_en, irr, isr, imr, read_isr
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// Fully-nested fixed priority (IR0 highest) over registered irr/isr/imr.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [IRQ_W-1:0] i_irr,
    input  logic [IRQ_W-1:0] i_imr,
    input  logic [IRQ_W-1:0] i_isr,
    output logic             o_winner_valid,
    output logic [LVL_W-1:0] o_winner_idx,
    output logic [LVL_W-1:0] o_highest_isr_idx
);

    logic [IRQ_W-1:0] w_cand;
    logic [LVL_W-1:0] w_win;
    logic [LVL_W-1:0] w_isr_low;

    // Lowest-index unmasked request and lowest-index in-service level
    always_comb begin
        w_cand    = i_irr & ~i_imr;
        w_win     = '0;
        w_isr_low = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win     = LVL_W'(i);
            if (i_isr[i])  w_isr_low = LVL_W'(i);
        end
    end

    assign o_winner_valid    = (|w_cand) && ((i_isr == '0) || (w_win < w_isr_low));
    assign o_winner_idx      = w_win;
    assign o_highest_isr_idx = w_isr_low;

endmodule

// File: rtl/pic_control_logic.sv
// IRR/ISR/IMR registers, IR sampling and the two-pulse INTA sequence.
module pic_control_logic
    import pic_pkg::*;
#(
    parameter int unsigned IR_SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pic_control_logic_if.slave  bus
);

    localparam int unsigned SYNC_N = (IR_SYNC_STAGES < 1) ? 1 : IR_SYNC_STAGES;

    logic [IRQ_W-1:0] r_ir_sync [SYNC_N];
    logic [IRQ_W-1:0] r_ir_prev;
    logic             r_inta_q;
    pic_state_t       r_state;
    logic             r_ltim;
    logic             r_aeoi;
    logic [4:0]       r_vec_base;
    logic [LVL_W-1:0] r_lvl;
    logic             r_spurious;
    logic [IRQ_W-1:0] r_lvl_blk;
    logic [IRQ_W-1:0] r_irr;
    logic [IRQ_W-1:0] r_isr;
    logic [IRQ_W-1:0] r_imr;
    logic             r_read_isr;
    logic             r_int_out;
    logic [IRQ_W-1:0] r_vector_out;
    logic             r_vector_en;

    logic [IRQ_W-1:0] w_ir_s;
    logic             w_win_valid_raw;
    logic             w_win_valid;
    logic [LVL_W-1:0] w_win_idx;
    logic [LVL_W-1:0] w_isr_low;
    logic             w_inta_fall;
    logic             w_inta_rise;
    logic             w_take;
    logic             w_inta2_end;
    logic [IRQ_W-1:0] w_inta_set;
    logic [IRQ_W-1:0] w_eoi_clr;
    logic [IRQ_W-1:0] w_aeoi_clr;
    logic [IRQ_W-1:0] w_isr_next;
    logic [IRQ_W-1:0] w_blk_next;
    logic [IRQ_W-1:0] w_irr_next;
    logic             w_unused;

    // ICW3 is meaningless in single mode
    assign w_unused = bus.icw_wr[ICW3];

    // Synchronizer chain for the asynchronous ir lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_N; s++) r_ir_sync[s] <= '0;
        end else begin
            r_ir_sync[0] <= bus.ir;
            for (int unsigned s = 1; s < SYNC_N; s++) r_ir_sync[s] <= r_ir_sync[s-1];
        end
    end

    assign w_ir_s = r_ir_sync[SYNC_N-1];

    pic_priority_resolver u_resolver (
        .i_irr             (r_irr),
        .i_imr             (r_imr),
        .i_isr             (r_isr),
        .o_winner_valid    (w_win_valid_raw),
        .o_winner_idx      (w_win_idx),
        .o_highest_isr_idx (w_isr_low)
    );

    assign w_win_valid = w_win_valid_raw & bus.end_of_init;

    // Next-state terms for irr/isr, including same-cycle EOI/INTA interaction
    always_comb begin
        w_inta_fall = r_inta_q & ~bus.inta_n;
        w_inta_rise = ~r_inta_q & bus.inta_n;
        w_take      = (r_state == WAIT_INTA1) && w_inta_fall && w_win_valid;
        w_inta2_end = (r_state == WAIT_INTA2) && r_vector_en && w_inta_rise;
        w_inta_set  = w_take ? lvl_mask(w_win_idx) : '0;

        w_eoi_clr = '0;
        if (bus.ocw_wr[OCW2]) begin
            case (bus.din[7:5])
                EOI_NS:  if (r_isr != '0) w_eoi_clr = lvl_mask(w_isr_low);
                EOI_SP:  w_eoi_clr = lvl_mask(bus.din[2:0]);
                default: w_eoi_clr = '0;
            endcase
        end

        w_aeoi_clr = (w_inta2_end && r_aeoi && !r_spurious) ? lvl_mask(r_lvl) : '0;
        w_isr_next = (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_inta_set;

        // Level mode: an acknowledged line stays out of irr until it drops
        w_blk_next = (r_lvl_blk & w_ir_s) | w_inta_set;
        if (r_ltim) w_irr_next = w_ir_s & ~w_blk_next;
        else        w_irr_next = (r_irr & ~w_inta_set) | (w_ir_s & ~r_ir_prev);
    end

    // Register file, INTA FSM and registered outputs; ICW1 overrides everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir_prev    <= '0;
            r_inta_q     <= 1'b1;
            r_state      <= IDLE;
            r_ltim       <= 1'b0;
            r_aeoi       <= 1'b0;
            r_vec_base   <= '0;
            r_lvl        <= '0;
            r_spurious   <= 1'b0;
            r_lvl_blk    <= '0;
            r_irr        <= '0;
            r_isr        <= '0;
            r_imr        <= '0;
            r_read_isr   <= 1'b0;
            r_int_out    <= 1'b0;
            r_vector_out <= '0;
            r_vector_en  <= 1'b0;
        end else begin
            r_inta_q  <= bus.inta_n;
            r_ir_prev <= w_ir_s;
            r_irr     <= w_irr_next;
            r_isr     <= w_isr_next;
            r_lvl_blk <= w_blk_next;

            if (bus.ocw_wr[OCW1]) r_imr <= bus.din;
            if (bus.ocw_wr[OCW3] && bus.din[1]) r_read_isr <= bus.din[0];
            if (bus.icw_wr[ICW2]) r_vec_base <= bus.din[7:3];
            if (bus.icw_wr[ICW4]) r_aeoi <= bus.din[1];

            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_int_out <= 1'b1;
                        r_state   <= WAIT_INTA1;
                    end
                end
                WAIT_INTA1: begin
                    if (w_inta_fall) begin
                        r_lvl      <= w_take ? w_win_idx : '1;
                        r_spurious <= ~w_take;
                        r_int_out  <= 1'b0;
                        r_state    <= WAIT_INTA2;
                    end
                end
                WAIT_INTA2: begin
                    if (w_inta_fall) begin
                        r_vector_out <= {r_vec_base, r_lvl};
                        r_vector_en  <= 1'b1;
                    end else if (w_inta2_end) begin
                        r_vector_en <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (bus.icw_wr[ICW1]) begin
                r_ltim      <= bus.din[3];
                r_irr       <= '0;
                r_isr       <= '0;
                r_imr       <= '0;
                r_lvl_blk   <= '0;
                r_ir_prev   <= '0;
                r_state     <= IDLE;
                r_int_out   <= 1'b0;
                r_vector_en <= 1'b0;
            end
        end
    end

    assign bus.int_out    = r_int_out;
    assign bus.vector_out = r_vector_out;
    assign bus.vector_en  = r_vector_en;
    assign bus.irr        = r_irr;
    assign bus.isr        = r_isr;
    assign bus.imr        = r_imr;
    assign bus.read_isr   = r_read_isr;

endmodule

// File: doc/pic_control_logic.md
Name: pic_control_logic

Overview:
- Downstream consumer of the 8259 read/write interface block.
- Takes the latched command byte and the ICW/OCW strobes, and holds the IRR, ISR and IMR registers.
- Resolves fully-nested fixed priority (IR0 highest) and runs the two-pulse INTA sequence that places the vector on the bus.
- Returns irr/isr/imr and the OCW3 read-select back to the read/write block.

Parameters:
IR_SYNC_STAGES, 2, flip-flop stages on the ir inputs before edge/level detection (minimum 1).

Ports:
clk  input  1  system clock; one clock domain, all logic on rising edge.
rst_n  input  1  reset, synchronous, active-low.
din  input  8  command byte from the read/write block (datatologic).
icw_wr  input  4  one-cycle write strobes; bit n = ICWn written (bits 4:1).
ocw_wr  input  3  one-cycle write strobes; bit n = OCWn written (bits 3:1).
end_of_init  input  1  high once the ICW sequence is complete.
ir  input  8  asynchronous interrupt request lines.
inta_n  input  1  interrupt acknowledge from the CPU, active-low.
int_out  output  1  interrupt request to the CPU.
vector_out  output  8  vector byte.
vector_en  output  1  high while vector_out must drive the data bus.
irr  output  8  interrupt request register.
isr  output  8  in-service register.
imr  output  8  interrupt mask register.
read_isr  output  1  OCW3 read select: 0 = IRR, 1 = ISR.

Behaviour:
- Reset (rst_n low at a clock edge):
  - int_out=0, vector_en=0, vector_out=0, irr=0, isr=0, imr=0, read_isr=0.
  - Latched ltim/aeoi/vec_base = 0; FSM = IDLE; synchronizer and inta history flops = 1 for inta, 0 for ir.
- ICW handling:
  - ICW1 strobe: ltim=din[3]; clears irr, isr, imr and edge history; forces FSM to IDLE; int_out=0 next cycle. This applies even mid-INTA (abort).
  - ICW2 strobe: vec_base=din[7:3].
  - ICW3 strobe: ignored (single mode only).
  - ICW4 strobe: aeoi=din[1].
- OCW handling:
  - OCW1 strobe: imr=din.
  - OCW2 strobe, on din[7:5]:
    - 001 = non-specific EOI: clear the lowest-index set isr bit.
    - 011 = specific EOI: clear isr[din[2:0]].
    - All other codes: no-op.
  - OCW3 strobe: if din[1]=1, read_isr=din[0]; else unchanged.
- IR sampling, on ir_s (the synchronized ir):
  - Edge mode (ltim=0): irr[i] set at the edge where ir_s[i]=1 and the previous ir_s[i]=0. It stays set until acknowledged or ICW1.
  - Level mode (ltim=1): irr[i] follows ir_s[i] every cycle, except the bit cleared at INTA1 stays clear while ir_s[i] stays high.
  - Masked bits still enter irr.
- Priority:
  - cand = irr & ~imr.
  - Winner = lowest-index cand bit, valid only if its index is strictly below the lowest set isr bit (or isr=0).
  - Priority uses registered irr/isr.
  - No requests are resolved while end_of_init=0.
- FSM, with inta falling edge = inta_n_q=1 and inta_n=0:
  - IDLE:
    - If a winner exists and end_of_init=1, set int_out=1 and go to WAIT_INTA1.
    - int_out asserts one cycle after the irr bit becomes visible.
  - WAIT_INTA1, on inta falling edge:
    - If a winner still exists: lvl=winner; isr[lvl]=1; irr[lvl]=0.
    - Else (spurious): lvl=7, isr unchanged.
    - In both cases: int_out=0, go to WAIT_INTA2.
  - WAIT_INTA2:
    - On inta falling edge: vector_out={vec_base,lvl} and vector_en=1.
    - vector_en holds while inta_n=0.
    - On inta_n rising: vector_en=0; if aeoi and the INTA was not spurious, clear isr[lvl]; go to IDLE.
- Simultaneous events: isr_next = (isr & ~eoi_clear & ~aeoi_clear) | inta_set. An EOI in the same cycle as INTA1 applies to the pre-set isr.
- vector_out holds its last value when vector_en=0.

Decomposition:
- Shared package pic_pkg holds:
  - ICW/OCW index constants (ICW1..ICW4, OCW1..OCW3).
  - OCW2 command codes (EOI_NS=3'b001, EOI_SP=3'b011).
  - FSM state typedef {IDLE, WAIT_INTA1, WAIT_INTA2}.
- One sub-module, pic_priority_resolver: combinational (irr, imr, isr) -> winner_valid, winner_idx[2:0], highest_isr_idx[2:0].

Test Plan:
- Init with ICW1=0x13, ICW2=0x40, ICW4=0x03 (AEOI), OCW1=0x00; pulse ir[3] -> irr=0x08 after sync, int_out=1 next cycle; two inta pulses -> vector_out=0x43 with vector_en only during the 2nd pulse; isr=0x00 after the 2nd pulse ends.
- ICW4=0x01 (no AEOI); ir[5] then ir[2] acknowledged -> isr=0x04 after IR2 INTA1, while ir[5] stays pending; OCW2=0x20 clears isr[2] -> IR5 then interrupts, vector 0x45.
- OCW1=0x08 masks IR3; raise ir[3] -> irr=0x08, int_out stays 0; OCW1=0x00 -> int_out=1.
- Raise ir[4], then drop it in level mode (ICW1=0x1B) before INTA1 -> spurious: vector_out={vec_base,3'b111}, isr unchanged.
- ISR=0x04 active; OCW2=0x62 (specific EOI, level 2) -> isr=0x00; OCW3=0x0B then 0x0A -> read_isr=1 then 0.
- Mid-WAIT_INTA2, ICW1 write -> FSM back to IDLE, irr/isr/imr=0, vector_en=0; rst_n low for one clk mid-sequence -> all outputs at their reset values.
